// File: rtl/sar_avg_sched.sv
// sar_avg_sched: schedules periodic SAR start pulses and averages 2^AVG_LOG2 results per output.
// Define AVG_ROUND_EN for round-half-up averaging; without it the average truncates.
module sar_avg_sched #(
  parameter int ADC_WIDTH = 8,
  parameter int AVG_LOG2  = 2,
  parameter int PERIOD    = 16,
  parameter int TIMEOUT   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  output logic                 start,
  input  logic                 den,
  input  logic [ADC_WIDTH-1:0] din,
  output logic [ADC_WIDTH-1:0] avg_data,
  output logic                 avg_valid,
  input  logic                 avg_ready,
  output logic                 overrun,
  output logic                 timeout,
  input  logic                 clr_err
);
  localparam int PCW  = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int TCW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int SCW  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int ACCW = ADC_WIDTH + AVG_LOG2;
  localparam int SUMW = ACCW + 1;
  localparam logic [PCW-1:0] P_LAST = PCW'(PERIOD - 1);
  localparam logic [TCW-1:0] T_LAST = TCW'(TIMEOUT - 1);
  localparam logic [SCW-1:0] S_LAST = SCW'((1 << AVG_LOG2) - 1);
`ifdef AVG_ROUND_EN
  localparam logic [SUMW-1:0] RND = SUMW'((1 << AVG_LOG2) >> 1);
`else
  localparam logic [SUMW-1:0] RND = '0;
`endif

  typedef enum logic {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_t;

  state_t               state_q, state_d;
  logic [PCW-1:0]       pcnt_q, pcnt_d;
  logic [TCW-1:0]       tcnt_q, tcnt_d;
  logic [SCW-1:0]       scnt_q, scnt_d;
  logic [ACCW-1:0]      acc_q, acc_d;
  logic                 start_q, start_d;
  logic [ADC_WIDTH-1:0] avg_data_q, avg_data_d;
  logic                 avg_valid_q, avg_valid_d;
  logic                 overrun_q, overrun_d;
  logic                 timeout_q, timeout_d;

  logic            go_wait, sample, tmo_hit, blk_done;
  logic [SUMW-1:0] sum, shifted;
  logic            unused_hi;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      pcnt_q      <= '0;
      tcnt_q      <= '0;
      scnt_q      <= '0;
      acc_q       <= '0;
      start_q     <= 1'b0;
      avg_data_q  <= '0;
      avg_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pcnt_q      <= pcnt_d;
      tcnt_q      <= tcnt_d;
      scnt_q      <= scnt_d;
      acc_q       <= acc_d;
      start_q     <= start_d;
      avg_data_q  <= avg_data_d;
      avg_valid_q <= avg_valid_d;
      overrun_q   <= overrun_d;
      timeout_q   <= timeout_d;
    end
  end

  assign go_wait  = (state_q == ST_IDLE) && enable && (pcnt_q == P_LAST);
  assign sample   = (state_q == ST_WAIT) && den;
  assign tmo_hit  = (state_q == ST_WAIT) && !den && (tcnt_q == T_LAST);
  assign blk_done = sample && (scnt_q == S_LAST);

  // Sum is one bit wider than acc so the rounding add can never wrap.
  assign sum       = SUMW'(acc_q) + SUMW'(din) + RND;
  assign shifted   = sum >> AVG_LOG2;
  assign unused_hi = ^shifted[SUMW-1:ADC_WIDTH];

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (go_wait) state_d = ST_WAIT;
      ST_WAIT: if (sample || tmo_hit) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    start_d = go_wait;

    // pcnt keeps running through WAIT so start-to-start spacing stays PERIOD.
    pcnt_d = pcnt_q;
    if (!enable || go_wait) pcnt_d = '0;
    else if (pcnt_q != P_LAST) pcnt_d = pcnt_q + PCW'(1);

    tcnt_d = tcnt_q;
    if (go_wait) tcnt_d = '0;
    else if ((state_q == ST_WAIT) && (tcnt_q != T_LAST)) tcnt_d = tcnt_q + TCW'(1);

    acc_d  = acc_q;
    scnt_d = scnt_q;
    if (blk_done) begin
      acc_d  = '0;
      scnt_d = '0;
    end else if (sample) begin
      acc_d  = acc_q + ACCW'(din);
      scnt_d = scnt_q + SCW'(1);
    end
    if ((sample || tmo_hit) && !enable) begin
      acc_d  = '0;
      scnt_d = '0;
    end

    avg_data_d  = blk_done ? shifted[ADC_WIDTH-1:0] : avg_data_q;
    avg_valid_d = blk_done || (avg_valid_q && !avg_ready);
    overrun_d   = (blk_done && avg_valid_q && !avg_ready) || (overrun_q && !clr_err);
    timeout_d   = tmo_hit || (timeout_q && !clr_err);
  end

  assign start     = start_q;
  assign avg_data  = avg_data_q;
  assign avg_valid = avg_valid_q;
  assign overrun   = overrun_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_sar_avg_sched.sv
// Bench for sar_avg_sched: emulates the SAR controller answering start pulses and checks
// start timing, block averages, handshake, sticky flags, reset and enable behaviour.
`timescale 1ns/1ps
module tb_sar_avg_sched;
  localparam int W = 8;
  localparam int L = 2;
  localparam int P = 16;
  localparam int T = 32;
  localparam int N = 1 << L;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         enable = 1'b0;
  logic         start;
  logic         den = 1'b0;
  logic [W-1:0] din = '0;
  logic [W-1:0] avg_data;
  logic         avg_valid;
  logic         avg_ready = 1'b1;
  logic         overrun;
  logic         timeout;
  logic         clr_err = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  sar_avg_sched #(.ADC_WIDTH(W), .AVG_LOG2(L), .PERIOD(P), .TIMEOUT(T)) dut (
    .clk(clk), .rst(rst), .enable(enable), .start(start), .den(den), .din(din),
    .avg_data(avg_data), .avg_valid(avg_valid), .avg_ready(avg_ready),
    .overrun(overrun), .timeout(timeout), .clr_err(clr_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: arithmetic mean of N samples, rounded half-up or truncated.
  function automatic logic [W-1:0] ref_avg(input int sum);
`ifdef AVG_ROUND_EN
    return W'((sum + N / 2) / N);
`else
    return W'(sum / N);
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_start(output bit ok, output int t);
    ok = 1'b0;
    t  = -1;
    for (int i = 0; i < 64 && !ok; i++) begin
      tick();
      if (start === 1'b1) begin
        ok = 1'b1;
        t  = cyc;
      end
    end
  endtask

  // SAR side: answer after lat cycles; flags any start seen while the conversion is open.
  task automatic respond(input logic [W-1:0] v, input int lat, output bit extra);
    extra = 1'b0;
    repeat (lat) begin
      tick();
      if (start !== 1'b0) extra = 1'b1;
    end
    den = 1'b1;
    din = v;
    tick();
    den = 1'b0;
    din = W'($urandom);
  endtask

  task automatic conv(input logic [W-1:0] v, input int lat, output int t, output bit ok);
    bit extra;
    wait_start(ok, t);
    respond(v, lat, extra);
    if (extra) ok = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (start !== 1'b0) begin errors++; $display("FAIL reset_start: got %b, expected 0", start); end
    checks++; if (avg_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, expected 0", avg_valid); end
    checks++; if (avg_data !== '0) begin errors++; $display("FAIL reset_data: got %0h, expected 0", avg_data); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b, expected 0", overrun); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b, expected 0", timeout); end
    rst = 1'b0;
  endtask

  task automatic test_constant();
    int t, tp, c0;
    bit ok;
    enable = 1'b1;
    c0 = cyc;
    tp = c0;
    for (int k = 0; k < 8; k++) begin
      conv(8'h99, 10, t, ok);
      checks++; if (!ok) begin errors++; $display("FAIL const_start k=%0d: start missing or not a single pulse", k); end
      checks++; if (t - tp !== P) begin errors++; $display("FAIL const_spacing k=%0d: got %0d, expected %0d", k, t - tp, P); end
      tp = t;
      if (k % N == N - 1) begin
        checks++;
        if (avg_valid !== 1'b1 || avg_data !== 8'h99)
          begin errors++; $display("FAIL const_avg k=%0d: got valid=%b data=%0h, expected valid=1 data=99", k, avg_valid, avg_data); end
      end else begin
        checks++; if (avg_valid !== 1'b0) begin errors++; $display("FAIL const_novalid k=%0d: got %b, expected 0", k, avg_valid); end
      end
    end
  endtask

  task automatic test_round();
    int t;
    bit ok;
    int vals[4] = '{10, 11, 11, 11};
    for (int k = 0; k < 4; k++) begin
      conv(W'(vals[k]), 10, t, ok);
      checks++; if (!ok) begin errors++; $display("FAIL round_start k=%0d: start missing or not a single pulse", k); end
    end
    checks++;
    if (avg_valid !== 1'b1 || avg_data !== ref_avg(43))
      begin errors++; $display("FAIL round_avg: got valid=%b data=%0d, expected valid=1 data=%0d", avg_valid, avg_data, ref_avg(43)); end
  endtask

  task automatic test_overrun();
    int t;
    bit ok;
    tick();
    avg_ready = 1'b0;
    for (int k = 0; k < 4; k++) conv(8'h20, 10, t, ok);
    checks++;
    if (avg_valid !== 1'b1 || avg_data !== 8'h20 || overrun !== 1'b0)
      begin errors++; $display("FAIL ovr_first: got valid=%b data=%0h ovr=%b, expected 1/20/0", avg_valid, avg_data, overrun); end
    for (int k = 0; k < 3; k++) conv(8'h40, 10, t, ok);
    checks++;
    if (avg_valid !== 1'b1 || avg_data !== 8'h20)
      begin errors++; $display("FAIL ovr_hold: got valid=%b data=%0h, expected 1/20", avg_valid, avg_data); end
    conv(8'h40, 10, t, ok);
    checks++;
    if (avg_valid !== 1'b1 || avg_data !== 8'h40 || overrun !== 1'b1)
      begin errors++; $display("FAIL ovr_second: got valid=%b data=%0h ovr=%b, expected 1/40/1", avg_valid, avg_data, overrun); end
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    checks++;
    if (overrun !== 1'b0 || avg_valid !== 1'b1 || avg_data !== 8'h40)
      begin errors++; $display("FAIL ovr_clear: got ovr=%b valid=%b data=%0h, expected 0/1/40", overrun, avg_valid, avg_data); end
    avg_ready = 1'b1;
    tick();
    checks++; if (avg_valid !== 1'b0) begin errors++; $display("FAIL ovr_accept: got valid=%b, expected 0", avg_valid); end
  endtask

  task automatic test_timeout();
    int t, t0, tr, t_exp, sum;
    bit ok, extra, bad;
    logic [W-1:0] v[4];
    for (int k = 0; k < 4; k++) v[k] = W'($urandom_range(0, 255));
    sum = int'(v[0]) + int'(v[1]) + int'(v[2]) + int'(v[3]);
    conv(v[0], 10, t, ok);
    conv(v[1], 10, t, ok);
    wait_start(ok, t0);
    checks++; if (!ok) begin errors++; $display("FAIL tmo_start: no start within bound"); end
    bad = 1'b0;
    while (cyc < t0 + T - 1) begin
      tick();
      if (timeout !== 1'b0 || start !== 1'b0) bad = 1'b1;
    end
    checks++; if (bad) begin errors++; $display("FAIL tmo_early: timeout or start seen before %0d cycles", T); end
    clr_err = 1'b1;
    tick();
    checks++;
    if (timeout !== 1'b1 || cyc - t0 !== T)
      begin errors++; $display("FAIL tmo_rise: got timeout=%b at +%0d, expected 1 at +%0d", timeout, cyc - t0, T); end
    tick();
    clr_err = 1'b0;
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL tmo_clear: got %b, expected 0", timeout); end
    // Retry: first idle edge once a full period has elapsed since the lost start.
    t_exp = (t0 + P > t0 + T + 1) ? t0 + P : t0 + T + 1;
    tr = cyc;
    checks++;
    if (start !== 1'b1 || tr !== t_exp)
      begin errors++; $display("FAIL tmo_retry: got start=%b at +%0d, expected 1 at +%0d", start, tr - t0, t_exp - t0); end
    respond(v[2], 10, extra);
    conv(v[3], 10, t, ok);
    checks++; if (t - tr !== P) begin errors++; $display("FAIL tmo_spacing: got %0d, expected %0d", t - tr, P); end
    checks++;
    if (avg_valid !== 1'b1 || avg_data !== ref_avg(sum))
      begin errors++; $display("FAIL tmo_avg: got valid=%b data=%0d, expected 1/%0d", avg_valid, avg_data, ref_avg(sum)); end
  endtask

  task automatic test_reset_mid();
    int t, c0, sum;
    bit ok;
    logic [W-1:0] v;
    tick();
    avg_ready = 1'b0;
    for (int k = 0; k < 6; k++) conv(W'($urandom_range(16, 255)), 10, t, ok);
    wait_start(ok, t);
    tick();
    tick();
    rst = 1'b1;
    tick();
    checks++;
    if (start !== 1'b0 || avg_valid !== 1'b0 || avg_data !== '0 || overrun !== 1'b0 || timeout !== 1'b0)
      begin errors++; $display("FAIL rstmid_outputs: got start=%b valid=%b data=%0h ovr=%b tmo=%b, expected all 0",
                               start, avg_valid, avg_data, overrun, timeout); end
    rst = 1'b0;
    avg_ready = 1'b1;
    c0 = cyc;
    sum = 0;
    for (int k = 0; k < 4; k++) begin
      v = W'($urandom_range(0, 255));
      sum += int'(v);
      conv(v, 10, t, ok);
      if (k == 0) begin
        checks++; if (t - c0 !== P) begin errors++; $display("FAIL rstmid_first: got %0d, expected %0d", t - c0, P); end
      end
    end
    checks++;
    if (avg_valid !== 1'b1 || avg_data !== ref_avg(sum))
      begin errors++; $display("FAIL rstmid_avg: got valid=%b data=%0d, expected 1/%0d", avg_valid, avg_data, ref_avg(sum)); end
  endtask

  task automatic test_enable_drop();
    int t, c0, sum;
    bit ok, extra, bad;
    logic [W-1:0] v;
    conv(W'($urandom_range(0, 255)), 10, t, ok);
    conv(W'($urandom_range(0, 255)), 10, t, ok);
    wait_start(ok, t);
    enable = 1'b0;
    respond(W'($urandom_range(0, 255)), 10, extra);
    checks++; if (avg_valid !== 1'b0 || extra) begin errors++; $display("FAIL endrop_done: got valid=%b extra_start=%b, expected 0/0", avg_valid, extra); end
    bad = 1'b0;
    repeat (3 * P) begin
      tick();
      if (start !== 1'b0 || avg_valid !== 1'b0) bad = 1'b1;
    end
    checks++; if (bad) begin errors++; $display("FAIL endrop_quiet: start or avg_valid seen while disabled"); end
    enable = 1'b1;
    c0 = cyc;
    sum = 0;
    for (int k = 0; k < 4; k++) begin
      v = W'($urandom_range(0, 255));
      sum += int'(v);
      conv(v, 10, t, ok);
      if (k == 0) begin
        checks++; if (t - c0 !== P) begin errors++; $display("FAIL endrop_first: got %0d, expected %0d", t - c0, P); end
      end
    end
    checks++;
    if (avg_valid !== 1'b1 || avg_data !== ref_avg(sum))
      begin errors++; $display("FAIL endrop_avg: got valid=%b data=%0d, expected 1/%0d", avg_valid, avg_data, ref_avg(sum)); end
  endtask

  task automatic test_random();
    int q[$];
    int t, tp, lat, sum;
    bit ok;
    logic [W-1:0] v;
    tp = -1;
    for (int k = 0; k < 20; k++) begin
      v   = W'($urandom_range(0, 255));
      lat = $urandom_range(1, 12);
      conv(v, lat, t, ok);
      checks++; if (!ok) begin errors++; $display("FAIL rand_start k=%0d: start missing or not a single pulse", k); end
      if (tp >= 0) begin
        checks++; if (t - tp !== P) begin errors++; $display("FAIL rand_spacing k=%0d: got %0d, expected %0d", k, t - tp, P); end
      end
      tp = t;
      q.push_back(int'(v));
      if (q.size() == N) begin
        sum = 0;
        while (q.size() > 0) sum += q.pop_front();
        checks++;
        if (avg_valid !== 1'b1 || avg_data !== ref_avg(sum))
          begin errors++; $display("FAIL rand_avg k=%0d: got valid=%b data=%0d, expected 1/%0d", k, avg_valid, avg_data, ref_avg(sum)); end
      end else begin
        checks++; if (avg_valid !== 1'b0) begin errors++; $display("FAIL rand_novalid k=%0d: got %b, expected 0", k, avg_valid); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_constant();
    test_round();
    test_overrun();
    test_timeout();
    test_reset_mid();
    test_enable_drop();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
